// File: rtl/change_dispenser.sv
// Greedy change payout (25/10/5) with empty-hopper fallback; pulse k lands in cycle 2+k*(GAP_CYCLES+2).
// Requests arriving while busy are dropped, not queued; all outputs decode from registered state.
module change_dispenser #(
    parameter int GAP_CYCLES = 4,
    parameter int AMT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amount,
    input  logic             hopper_empty_25,
    input  logic             hopper_empty_10,
    input  logic             hopper_empty_5,
    output logic             eject_25,
    output logic             eject_10,
    output logic             eject_5,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] leftover
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PULSE,
        GAP,
        DONE
    } state_t;

    localparam logic [AMT_W-1:0] C25 = AMT_W'(25);
    localparam logic [AMT_W-1:0] C10 = AMT_W'(10);
    localparam logic [AMT_W-1:0] C5  = AMT_W'(5);
    localparam logic [7:0]       GAP_LOAD = 8'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [AMT_W-1:0] remaining;
    logic [2:0]       coin;      // {quarter, dime, nickel}, one-hot while in PULSE
    logic [2:0]       pick;
    logic [AMT_W-1:0] coin_val;
    logic [7:0]       gap_cnt;

    always_comb begin
        pick = 3'b000;
        if (remaining >= C25 && !hopper_empty_25) begin
            pick = 3'b100;
        end else if (remaining >= C10 && !hopper_empty_10) begin
            pick = 3'b010;
        end else if (remaining >= C5 && !hopper_empty_5) begin
            pick = 3'b001;
        end
    end

    always_comb begin
        coin_val = '0;
        case (coin)
            3'b100:  coin_val = C25;
            3'b010:  coin_val = C10;
            3'b001:  coin_val = C5;
            default: coin_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        eject_25  = 1'b0;
        eject_10  = 1'b0;
        eject_5   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        short     = 1'b0;
        leftover  = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (change_valid) state_nxt = SELECT;
            end
            SELECT: begin
                state_nxt = (pick != 3'b000) ? PULSE : DONE;
            end
            PULSE: begin
                {eject_25, eject_10, eject_5} = coin;
                state_nxt = GAP;
            end
            GAP: begin
                if (gap_cnt == 8'd0) state_nxt = SELECT;
            end
            DONE: begin
                done      = 1'b1;
                short     = (remaining != '0);
                leftover  = remaining;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            coin      <= 3'b000;
            gap_cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (change_valid) remaining <= change_amount;
                end
                SELECT: begin
                    coin <= pick;
                end
                PULSE: begin
                    // pick guaranteed remaining >= coin, so this never wraps
                    remaining <= remaining - coin_val;
                    gap_cnt   <= GAP_LOAD;
                end
                GAP: begin
                    if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed payouts, ignored requests, mid-payout reset and
// randomized back-to-back payouts against a cycle-indexed payout model.
module tb_change_dispenser;

    localparam int G = 4;
    localparam int MAXC = 512;

    logic       clk;
    logic       reset;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       hopper_empty_25;
    logic       hopper_empty_10;
    logic       hopper_empty_5;
    logic       eject_25;
    logic       eject_10;
    logic       eject_5;
    logic       busy;
    logic       done;
    logic       short;
    logic [7:0] leftover;

    int total = 0;
    int bad   = 0;

    logic [2:0] hop    [0:MAXC-1];   // {empty25, empty10, empty5} driven during cycle c
    logic [2:0] exp_ej [0:MAXC-1];   // expected {eject_25, eject_10, eject_5} in cycle c

    change_dispenser #(.GAP_CYCLES(G), .AMT_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .change_valid    (change_valid),
        .change_amount   (change_amount),
        .hopper_empty_25 (hopper_empty_25),
        .hopper_empty_10 (hopper_empty_10),
        .hopper_empty_5  (hopper_empty_5),
        .eject_25        (eject_25),
        .eject_10        (eject_10),
        .eject_5         (eject_5),
        .busy            (busy),
        .done            (done),
        .short           (short),
        .leftover        (leftover)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // Caller must be at a negedge; the request is accepted at the following rising edge.
    task automatic run_txn(input logic [7:0] amt, input bit rand_hop, input logic [2:0] fixed_hop,
                           input bit spam, input string name,
                           output int o_done, output int o_pulses, output int o_first,
                           output int o_ndone, output logic o_short, output logic [7:0] o_left);
        int rem;
        int t;
        int coin;
        int exp_done;
        int exp_left;
        logic [2:0] cbits;
        logic [4:0] obs;
        logic [4:0] expv;
        for (int c = 0; c < MAXC; c++) begin
            exp_ej[c] = 3'b000;
            if (rand_hop)
                hop[c] = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            else
                hop[c] = fixed_hop;
        end
        // Payout model: SELECT at cycle t sees hop[t]; a chosen coin pulses at t+1, next SELECT at t+G+2.
        rem = int'(amt);
        t = 1;
        forever begin
            coin = 0;
            cbits = 3'b000;
            if (rem >= 25 && !hop[t][2]) begin coin = 25; cbits = 3'b100; end
            else if (rem >= 10 && !hop[t][1]) begin coin = 10; cbits = 3'b010; end
            else if (rem >= 5 && !hop[t][0]) begin coin = 5; cbits = 3'b001; end
            if (coin == 0) break;
            exp_ej[t+1] = cbits;
            rem = rem - coin;
            t = t + G + 2;
        end
        exp_done = t + 1;
        exp_left = rem;

        o_done = -1; o_pulses = 0; o_first = -1; o_ndone = 0; o_short = 1'b0; o_left = 8'd0;
        change_valid = 1'b1;
        change_amount = amt;
        {hopper_empty_25, hopper_empty_10, hopper_empty_5} = hop[0];
        for (int c = 1; c <= exp_done + 1; c++) begin
            @(negedge clk);
            {hopper_empty_25, hopper_empty_10, hopper_empty_5} = hop[c];
            if (spam && c <= exp_done) begin
                change_valid = 1'b1;
                change_amount = 8'($urandom_range(0, 255));
            end else begin
                change_valid = 1'b0;
            end
            obs  = {eject_25, eject_10, eject_5, busy, done};
            expv = {exp_ej[c], (c <= exp_done), (c == exp_done)};
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL %s amt=%0d cycle=%0d {ej25,ej10,ej5,busy,done}: got %b want %b",
                         name, amt, c, obs, expv);
            end
            if (eject_25 || eject_10 || eject_5) begin
                o_pulses++;
                if (o_first < 0) o_first = c;
            end
            if (done) begin
                o_ndone++;
                o_done = c;
                o_short = short;
                o_left = leftover;
            end
            if (c == exp_done) begin
                total++;
                if (short !== (exp_left != 0) || leftover !== 8'(exp_left)) begin
                    bad++;
                    $display("FAIL %s amt=%0d done-result: got short=%b leftover=%0d want short=%b leftover=%0d",
                             name, amt, short, leftover, (exp_left != 0), exp_left);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        change_valid = 1'b0;
        change_amount = 8'd0;
        {hopper_empty_25, hopper_empty_10, hopper_empty_5} = 3'b000;
        #2;
        total++;
        if ({eject_25, eject_10, eject_5, busy, done, short, leftover} !== 14'd0) begin
            bad++;
            $display("FAIL reset_values: got %b want all zero",
                     {eject_25, eject_10, eject_5, busy, done, short, leftover});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        int d, p, f, nd;
        logic s;
        logic [7:0] l;
        run_txn(8'd40, 1'b0, 3'b000, 1'b0, "amt40_full", d, p, f, nd, s, l);
        total++;
        if (d !== 20 || p !== 3 || f !== 2 || s !== 1'b0 || l !== 8'd0) begin
            bad++;
            $display("FAIL amt40_summary: got done=%0d pulses=%0d first=%0d short=%b left=%0d want 20 3 2 0 0", d, p, f, s, l);
        end
        run_txn(8'd30, 1'b0, 3'b100, 1'b0, "amt30_noq", d, p, f, nd, s, l);
        total++;
        if (d !== 20 || p !== 3 || s !== 1'b0 || l !== 8'd0) begin
            bad++;
            $display("FAIL amt30_summary: got done=%0d pulses=%0d short=%b left=%0d want 20 3 0 0", d, p, s, l);
        end
        run_txn(8'd42, 1'b0, 3'b000, 1'b0, "amt42_full", d, p, f, nd, s, l);
        total++;
        if (d !== 20 || p !== 3 || s !== 1'b1 || l !== 8'd2) begin
            bad++;
            $display("FAIL amt42_summary: got done=%0d pulses=%0d short=%b left=%0d want 20 3 1 2", d, p, s, l);
        end
        run_txn(8'd25, 1'b0, 3'b111, 1'b0, "amt25_empty", d, p, f, nd, s, l);
        total++;
        if (d !== 2 || p !== 0 || s !== 1'b1 || l !== 8'd25) begin
            bad++;
            $display("FAIL amt25_empty_summary: got done=%0d pulses=%0d short=%b left=%0d want 2 0 1 25", d, p, s, l);
        end
        run_txn(8'd0, 1'b0, 3'b000, 1'b0, "amt0", d, p, f, nd, s, l);
        total++;
        if (d !== 2 || p !== 0 || s !== 1'b0 || l !== 8'd0) begin
            bad++;
            $display("FAIL amt0_summary: got done=%0d pulses=%0d short=%b left=%0d want 2 0 0 0", d, p, s, l);
        end
    endtask

    task automatic test_ignore_busy();
        int d, p, f, nd;
        logic s;
        logic [7:0] l;
        run_txn(8'd75, 1'b0, 3'b000, 1'b1, "amt75_spam", d, p, f, nd, s, l);
        total++;
        if (p !== 3 || nd !== 1 || d !== 20 || s !== 1'b0) begin
            bad++;
            $display("FAIL ignore_busy: got pulses=%0d dones=%0d done=%0d short=%b want 3 1 20 0", p, nd, d, s);
        end
    endtask

    task automatic test_reset_mid();
        int d, p, f, nd;
        logic s;
        logic [7:0] l;
        {hopper_empty_25, hopper_empty_10, hopper_empty_5} = 3'b000;
        change_valid = 1'b1;
        change_amount = 8'd75;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            change_valid = 1'b0;
        end
        reset = 1'b0;
        #1;
        total++;
        if ({eject_25, eject_10, eject_5, busy, done, short, leftover} !== 14'd0) begin
            bad++;
            $display("FAIL reset_mid_immediate: got %b want all zero",
                     {eject_25, eject_10, eject_5, busy, done, short, leftover});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({eject_25, eject_10, eject_5, busy, done} !== 5'd0) begin
                bad++;
                $display("FAIL reset_mid_held: got %b want 00000", {eject_25, eject_10, eject_5, busy, done});
            end
        end
        reset = 1'b1;
        run_txn(8'd5, 1'b0, 3'b000, 1'b0, "after_reset_amt5", d, p, f, nd, s, l);
        total++;
        if (f !== 2 || d !== 8 || p !== 1) begin
            bad++;
            $display("FAIL after_reset_amt5: got first=%0d done=%0d pulses=%0d want 2 8 1", f, d, p);
        end
    endtask

    task automatic test_back_to_back();
        int d, p, f, nd;
        logic s;
        logic [7:0] l;
        for (int i = 0; i < 40; i++) begin
            run_txn(8'($urandom_range(0, 255)), 1'b1, 3'b000, ($urandom_range(0, 1) == 1),
                    "random", d, p, f, nd, s, l);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
